// File: rtl/div_iter_if.sv
// Request/response bundle between a pipeline and the iterative divider.
// The master issues operands; the slave (divider) returns stall, results and the zero-divisor flag.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             annul_i;
    logic             signed_i;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic             busy_o;
    logic             ready_o;
    logic [WIDTH-1:0] quot_o;
    logic [WIDTH-1:0] rem_o;
    logic             dbz_o;

    modport master (
        output start_i, annul_i, signed_i, opa_i, opb_i,
        input  busy_o, ready_o, quot_o, rem_o, dbz_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opa_i, opb_i,
        output busy_o, ready_o, quot_o, rem_o, dbz_o
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider (DIV/DIVU): one quotient bit per cycle on magnitudes,
// sign fix-up on the way into DONE, divide-by-zero answered in a single cycle.
module div_iter #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    div_iter_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] part_r;      // partial remainder
    logic [WIDTH-1:0] quo_r;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div_r;       // divisor magnitude
    logic             qsign_r;
    logic             rsign_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;
    logic             dbz_r;
    logic             ready_r;

    logic             signed_op_s;
    logic             accept_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] part_next_s;
    logic [WIDTH-1:0] quo_next_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] val,
                                                  input logic           neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    assign signed_op_s = SIGNED_EN && bus.signed_i;
    assign accept_s    = bus.start_i && !bus.annul_i;

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    always_comb begin
        shifted_s = {part_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, div_r};
        if (diff_s[WIDTH] == 1'b0) begin
            part_next_s = diff_s[WIDTH-1:0];
            quo_next_s  = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            part_next_s = shifted_s[WIDTH-1:0];
            quo_next_s  = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            count_r <= {CNT_W{1'b0}};
            part_r  <= ZERO_W;
            quo_r   <= ZERO_W;
            div_r   <= ZERO_W;
            qsign_r <= 1'b0;
            rsign_r <= 1'b0;
            quot_r  <= ZERO_W;
            rem_r   <= ZERO_W;
            dbz_r   <= 1'b0;
            ready_r <= 1'b0;
        end else if (bus.annul_i) begin
            // Flush: drop whatever is in flight, leave the last results visible.
            state_r <= IDLE;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (accept_s) begin
                        if (bus.opb_i == ZERO_W) begin
                            state_r <= DONE;
                            quot_r  <= ALL_ONES;
                            rem_r   <= bus.opa_i;
                            dbz_r   <= 1'b1;
                            ready_r <= 1'b1;
                        end else begin
                            state_r <= CALC;
                            count_r <= {CNT_W{1'b0}};
                            part_r  <= ZERO_W;
                            quo_r   <= cond_neg(bus.opa_i, signed_op_s && bus.opa_i[WIDTH-1]);
                            div_r   <= cond_neg(bus.opb_i, signed_op_s && bus.opb_i[WIDTH-1]);
                            qsign_r <= signed_op_s && (bus.opa_i[WIDTH-1] ^ bus.opb_i[WIDTH-1]);
                            rsign_r <= signed_op_s && bus.opa_i[WIDTH-1];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    part_r <= part_next_s;
                    quo_r  <= quo_next_s;
                    if (count_r == LAST_CNT) begin
                        state_r <= DONE;
                        quot_r  <= cond_neg(quo_next_s, qsign_r);
                        rem_r   <= cond_neg(part_next_s, rsign_r);
                        dbz_r   <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so the requesting instruction holds in its own cycle.
    assign bus.busy_o  = (state_r == CALC) || ((state_r == IDLE) && accept_s);
    assign bus.ready_o = ready_r;
    assign bus.quot_o  = quot_r;
    assign bus.rem_o   = rem_r;
    assign bus.dbz_o   = dbz_r;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter (WIDTH=32): directed corner cases plus random operands,
// checked against a plain-arithmetic reference with latency tracking.
module tb_div_iter;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_z;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time the ready pulse.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus.ready_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quot", 64'(bus.quot_o), 64'(e.q));
                check("rem", 64'(bus.rem_o), 64'(e.r));
                check("dbz", 64'(bus.dbz_o), 64'(e.z));
                check("latency", 64'(cyc), 64'(e.due));
                check("busy_in_done", 64'(bus.busy_o), 64'd0);
                last_q = e.q;
                last_r = e.r;
                last_z = e.z;
            end
        end
    end

    // Present a request; sync=0 means the caller already sits between edges before the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit sync, input bit noise);
        exp_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        bus.start_i  = 1'b1;
        bus.annul_i  = 1'b0;
        bus.signed_i = s;
        bus.opa_i    = a;
        bus.opb_i    = b;
        #1;
        check("busy_on_start", 64'(bus.busy_o), 64'd1);
        model(a, b, s, e.q, e.r, e.z);
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.signed_i = 1'($urandom_range(0, 1));
        bus.opa_i    = $urandom;
        bus.opb_i    = $urandom;
        e.due = cyc + ((e.z) ? 0 : W);
        sb_q.push_back(e);
        if (noise && !e.z) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
            bus.start_i = 1'b1;
            bus.opb_i   = $urandom_range(1, 9);
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        issue(a, b, s, 1'b1, 1'b0);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_vec = 0;
        n_err = 0;
        last_q = 32'd0;
        last_r = 32'd0;
        last_z = 1'b0;
        rst = 1'b0;
        bus.start_i  = 1'b0;
        bus.annul_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.opa_i    = 32'd0;
        bus.opb_i    = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd0);
        check("rst_quot", 64'(bus.quot_o), 64'd0);
        check("rst_rem", 64'(bus.rem_o), 64'd0);
        check("rst_dbz", 64'(bus.dbz_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFF9, 32'h2, 1'b1);
        run(32'hFFFF_FFF9, 32'h2, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'h0000_1234, 32'd0, 1'b0);
        run(32'h0000_1234, 32'd0, 1'b1);

        // Annul at CALC cycle 10: nothing delivered, results untouched, then a fresh op.
        issue(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        sb_q.delete();
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("annul_busy", 64'(bus.busy_o), 64'd0);
        check("annul_quot", 64'(bus.quot_o), 64'(last_q));
        check("annul_rem", 64'(bus.rem_o), 64'(last_r));
        check("annul_dbz", 64'(bus.dbz_o), 64'(last_z));
        issue(32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
        drain();

        // Start together with annul must not launch anything.
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        bus.opa_i   = 32'd77;
        bus.opb_i   = 32'd3;
        #1;
        check("start_annul_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        #1;
        check("start_annul_idle", 64'(bus.busy_o), 64'd0);
        repeat (40) @(posedge clk);

        // Asynchronous reset between edges mid-CALC, then accept on the first edge after release.
        issue(32'd1000, 32'd3, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        sb_q.delete();
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_quot", 64'(bus.quot_o), 64'd0);
        check("arst_rem", 64'(bus.rem_o), 64'd0);
        check("arst_ready", 64'(bus.ready_o), 64'd0);
        last_q = 32'd0;
        last_r = 32'd0;
        last_z = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        issue(32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
        drain();

        // Random operands with assorted corner classes and ignored starts mid-operation.
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = b >> $urandom_range(0, 31);
                default: a = a;
            endcase
            issue(a, b, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width; legal values are even and >= 4.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 0, signed_i is ignored and all divisions are unsigned.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port start_i  input  1  request to begin a division; sampled only in IDLE.
REQ-006 Port annul_i  input  1  cancels the operation in flight (exception flush).
REQ-007 Port signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-008 Port opa_i  input  WIDTH  dividend.
REQ-009 Port opb_i  input  WIDTH  divisor.
REQ-010 Port busy_o  output  1  high while an operation is in flight; used as the pipeline stall.
REQ-011 Port ready_o  output  1  single-cycle pulse when the result is valid.
REQ-012 Port quot_o  output  WIDTH  quotient (LO).
REQ-013 Port rem_o  output  WIDTH  remainder (HI).
REQ-014 Port dbz_o  output  1  divisor was zero; valid while ready_o is high.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 IDLE -> CALC SHALL occur when start_i=1, annul_i=0 and opb_i!=0. The block SHALL latch |opa_i|, |opb_i|, the quotient sign (opa[MSB]^opb[MSB], signed only) and the remainder sign (opa[MSB], signed only).
REQ-017 IDLE -> DONE SHALL occur when start_i=1, annul_i=0 and opb_i==0. The result SHALL be quot = all ones, rem = opa_i, dbz_o=1.
REQ-018 CALC SHALL perform one restoring radix-2 step per cycle for exactly WIDTH cycles, counted by an internal counter, and then go to DONE.
REQ-019 DONE SHALL last exactly one cycle, with ready_o=1; the next state SHALL be IDLE.
REQ-020 Latency: with start accepted at edge t, ready_o SHALL be high in the cycle after edge t+WIDTH; divide-by-zero SHALL give ready_o in the cycle after edge t.
REQ-021 busy_o SHALL be 1 in CALC, and 1 in IDLE when start_i=1 and annul_i=0 (combinational, so the requesting instruction stalls immediately); it SHALL be 0 in DONE.
REQ-022 Sign correction SHALL be applied when entering DONE: the quotient is negated if the quotient sign is 1, and the remainder is negated if the remainder sign is 1.
REQ-023 Signed most-negative / -1 SHALL give quot = 1 followed by WIDTH-1 zeros (wrap-around) and rem = 0, with no flag.
REQ-024 quot_o, rem_o and dbz_o SHALL hold their values from DONE until the next accepted start; start_i in CALC or DONE SHALL be ignored.
REQ-025 annul_i=1 in any state SHALL force IDLE at the next edge. No ready_o pulse SHALL follow, and outputs SHALL keep their previous values.
REQ-026 annul_i and start_i high in the same IDLE cycle SHALL not start an operation.
REQ-027 Operand inputs SHALL be don't-care after the start cycle.

Reset
REQ-028 While rst=0: state SHALL be IDLE; busy_o, ready_o and dbz_o SHALL be 0; quot_o, rem_o and the counter SHALL be 0; this SHALL hold from assertion, independent of clk.
REQ-029 Reset asserted mid-CALC SHALL abort the operation with no ready_o pulse.
REQ-030 After reset release, the first rising edge SHALL be able to accept start_i.

Verification (WIDTH=32)
REQ-031 Unsigned 100/7 -> busy for 33 cycles; ready_o pulse in the 33rd cycle after start; quot=14, rem=2, dbz=0.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x2) -> quot=0xFFFFFFFD, rem=0xFFFFFFFF; same signed operands with signed_i=0 -> quot=0x7FFFFFFC, rem=1.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
REQ-034 opb=0, opa=0x1234 -> ready_o the cycle after start; quot=0xFFFFFFFF, rem=0x1234, dbz_o=1.
REQ-035 annul_i pulsed at CALC cycle 10 -> IDLE next cycle, no ready_o, outputs unchanged; an immediate new start 50/5 -> quot=10, rem=0 at normal latency.
REQ-036 rst driven low mid-CALC, between clock edges -> busy_o, quot_o and rem_o go to 0 immediately; no ready_o after release.
